// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Covers the fetch FSM encoding, the PC step and the branch-target alignment mask.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam int PC_INCR = 4;

  // Sliced to the address width at the point of use.
  localparam logic [63:0] ALIGN_MASK = ~64'd3;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO holding {instruction, pc} pairs for the fetch unit.
// A flush empties it and overrides any push or pop arriving at the same edge.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [2*W-1:0]           push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [2*W-1:0]           head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*W-1:0] mem_q [DEPTH];
  logic [2*W-1:0] mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A push into a full FIFO is accepted only when the head leaves at the same edge.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding req/ack memory read per instruction, buffered
// in a small FIFO for decode; a taken branch redirects, flushes and drops in-flight data.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int           W          = 32,
  parameter int           DEPTH      = 2,
  parameter logic [W-1:0] RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset_asynchronous,
  input  logic         branch_taken,
  input  logic [W-1:0] branch_target,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [W-1:0] instr,
  output logic [W-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e   state_q, state_d;
  logic [W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [W-1:0]   addr_q, addr_d;
  logic           req_q, req_d;
  logic           push, pop;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [2*W-1:0] fifo_head;
  logic [W-1:0]   next_pc, target_aligned;
  logic           slot_free_idle, slot_free_after_ack;

  assign next_pc        = fetch_pc_q + W'(PC_INCR);
  assign target_aligned = branch_target & ALIGN_MASK[W-1:0];

  assign push = (state_q == FETCH) && imem_ack && !branch_taken;
  assign pop  = instr_valid && instr_ready && !branch_taken;

  // Nothing is outstanding in IDLE, so a free slot simply means the FIFO is not full.
  assign slot_free_idle      = !fifo_full;
  assign slot_free_after_ack = ({1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(pop)) < (CW+1)'(DEPTH);

  always_ff @(posedge clk or posedge reset_asynchronous) begin
    if (reset_asynchronous) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (branch_taken) begin
      fetch_pc_d = target_aligned;
      case (state_q)
        FETCH:   state_d = imem_ack ? IDLE : DROP;
        DROP:    state_d = imem_ack ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (slot_free_idle) state_d = FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            fetch_pc_d = next_pc;
            state_d    = slot_free_after_ack ? FETCH : IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A new address is launched on entering FETCH or on a back-to-back ack; otherwise it holds.
  always_comb begin
    req_d  = (state_d != IDLE);
    addr_d = addr_q;
    if (state_d == FETCH && (state_q == IDLE || imem_ack)) begin
      addr_d = fetch_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset_asynchronous),
    .push      (push),
    .push_data ({imem_rdata, addr_q}),
    .pop       (pop),
    .flush     (branch_taken),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid       = !fifo_empty;
  assign {instr, instr_pc} = fifo_head;

endmodule
